// File: rtl/sdram_clk_sequencer_pkg.sv
// Shared state encodings and helpers for the SDRAM PLL clock sequencer.
package sdram_clk_sequencer_pkg;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StPllRst   = 3'd1;
  localparam logic [2:0] StWaitLock = 3'd2;
  localparam logic [2:0] StStable   = 3'd3;
  localparam logic [2:0] StInit     = 3'd4;
  localparam logic [2:0] StReady    = 3'd5;
  localparam logic [2:0] StError    = 3'd6;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sdram_clk_sequencer_sync_2ff.sv
// 1-bit double-flop synchronizer for inputs asynchronous to the reference clock.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sdram_clk_sequencer.sv
// PLL bring-up supervisor: pulses PLL reset, qualifies lock, releases and inits the
// SDRAM controller, and re-sequences on lock loss or failed attempts.
module sdram_clk_sequencer
  import sdram_clk_sequencer_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = 8,
  parameter int unsigned LOCK_TIMEOUT   = 50000,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned INIT_TIMEOUT   = 20000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned RW             = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_enable,
  input  logic          i_pll_locked,
  input  logic          i_init_done,
  output logic          o_pll_rst,
  output logic          o_sdram_rst,
  output logic          o_init_req,
  output logic          o_ready,
  output logic          o_error,
  output logic          o_lock_lost,
  output logic [RW-1:0] o_retry_count,
  output logic [2:0]    o_state
);

  localparam int unsigned CntMax = max_u(max_u(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                         max_u(STABLE_CYCLES, INIT_TIMEOUT));
  localparam int unsigned CntW   = $clog2(CntMax) + 1;

  logic            w_locked_s;
  logic            w_done_s;
  logic [2:0]      r_state;
  logic [2:0]      w_state_d;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;
  logic            w_cnt_zero;
  logic [RW-1:0]   r_retry_count;
  logic [RW-1:0]   w_retry_d;
  logic            w_fail;
  logic            w_drop;
  logic            r_lock_lost;
  logic            w_lock_lost_d;
  logic            r_pll_rst;
  logic            r_sdram_rst;
  logic            r_init_req;
  logic            r_ready;
  logic            r_error;

  sync_2ff u_sync_locked (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_pll_locked),
    .o_q     (w_locked_s)
  );

  sync_2ff u_sync_done (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_init_done),
    .o_q     (w_done_s)
  );

  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state_d = r_state;
    w_fail    = 1'b0;
    w_drop    = 1'b0;
    case (r_state)
      StIdle:     if (i_enable) w_state_d = StPllRst;
      StPllRst:   if (w_cnt_zero) w_state_d = StWaitLock;
      StWaitLock: begin
        if (w_locked_s)      w_state_d = StStable;
        else if (w_cnt_zero) w_fail = 1'b1;
      end
      StStable: begin
        if (!w_locked_s)     w_fail = 1'b1;
        else if (w_cnt_zero) w_state_d = StInit;
      end
      // Lock loss outranks a simultaneous init_done.
      StInit: begin
        if (!w_locked_s)     w_fail = 1'b1;
        else if (w_done_s)   w_state_d = StReady;
        else if (w_cnt_zero) w_fail = 1'b1;
      end
      StReady: begin
        if (!w_locked_s) begin
          w_drop    = 1'b1;
          w_state_d = StPllRst;
        end
      end
      StError:    w_state_d = StError;
      default:    w_state_d = StIdle;
    endcase

    w_retry_d = r_retry_count;
    if (w_fail) begin
      if (r_retry_count == RW'(MAX_RETRIES)) begin
        w_state_d = StError;
      end else begin
        w_state_d = StPllRst;
        w_retry_d = r_retry_count + RW'(1);
      end
    end
    if (w_state_d == StReady) w_retry_d = '0;

    w_lock_lost_d = r_lock_lost | w_drop;

    if (!i_enable) begin
      w_state_d     = StIdle;
      w_retry_d     = '0;
      w_lock_lost_d = 1'b0;
    end
  end

  // Reload on every state entry so each state times its own dwell.
  always_comb begin
    w_cnt_d = w_cnt_zero ? '0 : r_cnt - CntW'(1);
    if (w_state_d != r_state) begin
      case (w_state_d)
        StPllRst:   w_cnt_d = CntW'(PLL_RST_CYCLES - 1);
        StWaitLock: w_cnt_d = CntW'(LOCK_TIMEOUT - 1);
        StStable:   w_cnt_d = CntW'(STABLE_CYCLES - 1);
        StInit:     w_cnt_d = CntW'(INIT_TIMEOUT - 1);
        default:    w_cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_retry_count <= '0;
      r_lock_lost   <= 1'b0;
      r_pll_rst     <= 1'b1;
      r_sdram_rst   <= 1'b1;
      r_init_req    <= 1'b0;
      r_ready       <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_cnt         <= w_cnt_d;
      r_retry_count <= w_retry_d;
      r_lock_lost   <= w_lock_lost_d;
      r_pll_rst     <= (w_state_d == StIdle) || (w_state_d == StPllRst) ||
                       (w_state_d == StError);
      r_sdram_rst   <= !((w_state_d == StInit) || (w_state_d == StReady));
      r_init_req    <= (w_state_d == StInit);
      r_ready       <= (w_state_d == StReady);
      r_error       <= (w_state_d == StError);
    end
  end

  assign o_pll_rst     = r_pll_rst;
  assign o_sdram_rst   = r_sdram_rst;
  assign o_init_req    = r_init_req;
  assign o_ready       = r_ready;
  assign o_error       = r_error;
  assign o_lock_lost   = r_lock_lost;
  assign o_retry_count = r_retry_count;
  assign o_state       = r_state;

endmodule
